// File: rtl/cdb_broadcaster.sv
// Complete-stage CDB driver: per-FU result FIFOs, round-robin select, registered broadcast bus.
// Latency: a result pushed at the end of cycle t is broadcast in cycle t+2 at the earliest.
// Backpressure: fu_ready[i] is low while FIFO i is full; a push against low ready is dropped and flagged.

// Small generic FIFO used for each functional-unit holding buffer.
// Latency: head visible the cycle after a push into an empty FIFO.
// Backpressure: caller must gate push with !full and pop with !empty.
module cdb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  // Storage write; entries need no reset because validity is carried by count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointer and occupancy update; reset and flush both discard every entry.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

module cdb_broadcaster #(
  parameter int NUM_FU    = 4,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_value,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [$clog2(NUM_FU)-1:0]  cdb_fu_id,
  output logic                       overflow_err
);
  localparam int ID_W = $clog2(NUM_FU);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_FU - 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } result_t;

  result_t           head [NUM_FU];
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     scan;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign fu_ready[i] = ~full[i];
    assign push[i]     = fu_valid[i] & ~full[i] & ~squash;
    assign pop[i]      = grant_vld & (grant_id == ID_W'(i)) & ~squash;

    cdb_fifo #(
      .WIDTH ($bits(result_t)),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .flush  (squash),
      .push   (push[i]),
      .pop    (pop[i]),
      .wr_dat ({fu_tag[i*TAG_W +: TAG_W], fu_value[i*DATA_W +: DATA_W]}),
      .rd_dat (head[i]),
      .full   (full[i]),
      .empty  (empty[i])
    );
  end

  // Round-robin pick: first non-empty FIFO scanning upward from rr_ptr, wrapping at NUM_FU.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_FU)) scan = scan - (ID_W+1)'(NUM_FU);
      if (!grant_vld && !empty[scan[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = scan[ID_W-1:0];
      end
    end
  end

  // Registered CDB and arbitration pointer; squash kills the next broadcast but keeps rr_ptr.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_fu_id <= '0;
    end else if (squash) begin
      cdb_valid <= 1'b0;
    end else if (grant_vld) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= head[grant_id].tag;
      cdb_value <= head[grant_id].value;
      cdb_fu_id <= grant_id;
      rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

  // Sticky flag for a result offered to a full FIFO; a squashed offer is not an overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (!squash && |(fu_valid & ~fu_ready)) begin
      overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;
  localparam int DEPTH = 2;

  logic         clock;
  logic         reset;
  logic         squash;
  logic [3:0]   fu_valid;
  logic [19:0]  fu_tag;
  logic [127:0] fu_value;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_fu_id;
  logic         overflow_err;

  cdb_broadcaster #(.NUM_FU(4), .TAG_W(5), .DATA_W(32), .BUF_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .fu_valid     (fu_valid),
    .fu_tag       (fu_tag),
    .fu_value     (fu_value),
    .fu_ready     (fu_ready),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .cdb_fu_id    (cdb_fu_id),
    .overflow_err (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: one queue of pending results per FU plus the expected bus contents.
  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] value;
  } res_t;

  res_t        q [4][$];
  int          rr;
  logic        e_valid;
  logic [4:0]  e_tag;
  logic [31:0] e_value;
  logic [1:0]  e_id;
  logic        e_ovf;
  bit          armed;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] tags4(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] d);
    return {d, c, b, a};
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic r, input logic s, input logic [3:0] v,
                      input logic [19:0] t, input logic [127:0] d,
                      input bit gate, output logic [3:0] acc);
    logic [3:0] m_rdy;
    logic [3:0] v_eff;
    int         w;
    res_t       item;
    @(negedge clock);
    for (int i = 0; i < 4; i++) m_rdy[i] = (q[i].size() < DEPTH);
    if (armed) begin
      chk("cdb_valid",    64'(cdb_valid),    64'(e_valid));
      chk("cdb_tag",      64'(cdb_tag),      64'(e_tag));
      chk("cdb_value",    64'(cdb_value),    64'(e_value));
      chk("cdb_fu_id",    64'(cdb_fu_id),    64'(e_id));
      chk("overflow_err", 64'(overflow_err), 64'(e_ovf));
      chk("fu_ready",     64'(fu_ready),     64'(m_rdy));
    end
    v_eff    = gate ? (v & m_rdy) : v;
    reset    = r;
    squash   = s;
    fu_valid = v_eff;
    fu_tag   = t;
    fu_value = d;
    acc      = 4'b0;
    if (r) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      rr = 0; e_valid = 0; e_tag = 0; e_value = 0; e_id = 0; e_ovf = 0;
      armed = 1;
    end else if (s) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      e_valid = 0;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && q[(rr + k) % 4].size() > 0) w = (rr + k) % 4;
      if (w >= 0) begin
        item    = q[w].pop_front();
        e_valid = 1;
        e_tag   = item.tag;
        e_value = item.value;
        e_id    = 2'(w);
        rr      = (w + 1) % 4;
      end else begin
        e_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (v_eff[i]) begin
          if (m_rdy[i]) begin
            item.tag   = t[i*5 +: 5];
            item.value = d[i*32 +: 32];
            q[i].push_back(item);
            acc[i] = 1'b1;
          end else begin
            e_ovf = 1;
          end
        end
      end
    end
  endtask

  initial begin
    logic [3:0]   acc;
    logic [3:0]   v;
    logic [19:0]  t;
    logic [127:0] d;
    int           sent2;
    bit           r_in;
    bit           s_in;
    n_assert = 0; n_fail = 0; armed = 0; rr = 0;
    e_valid = 0; e_tag = 0; e_value = 0; e_id = 0; e_ovf = 0;
    reset = 1; squash = 0; fu_valid = 0; fu_tag = 0; fu_value = 0;

    // Single result on FU1: broadcast two cycles after the push, idle around it.
    step(1, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(1, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(0, 0, 4'b0010, tags4(0, 5, 0, 0), {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, 0, acc);
    for (int c = 0; c < 4; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    // All four FUs at once after reset: FU order 0..3, pointer back at 0.
    step(1, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(0, 0, 4'hF, tags4(1, 2, 3, 4), {32'h44, 32'h33, 32'h22, 32'h11}, 0, acc);
    for (int c = 0; c < 6; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(0, 0, 4'b0011, tags4(7, 8, 0, 0), {32'h0, 32'h0, 32'h88, 32'h77}, 0, acc);
    for (int c = 0; c < 3; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    // FU2 sends three results against a continuously pushing FU0; FU2 respects ready.
    sent2 = 0;
    for (int c = 0; c < 12; c++) begin
      v = 4'b0001 | ((sent2 < 3) ? 4'b0100 : 4'b0000);
      t = tags4(5'(10 + c), 0, 5'(20 + sent2), 0);
      d = {32'h0, 32'(32'hC200 + sent2), 32'h0, 32'(32'hA000 + c)};
      step(0, 0, v, t, d, 1, acc);
      if (acc[2]) sent2++;
    end
    for (int c = 0; c < 6; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    // Contention fills FIFOs; ungated pushes overflow, flag survives squash, reset clears it.
    for (int c = 0; c < 4; c++)
      step(0, 0, 4'hF, tags4(5'(c), 5'(c + 4), 5'(c + 8), 5'(c + 12)),
           {$urandom, $urandom, $urandom, $urandom}, 0, acc);
    for (int c = 0; c < 3; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(0, 1, 4'b0, 20'b0, 128'b0, 0, acc);
    for (int c = 0; c < 8; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(1, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    // Five buffered results, then squash with a simultaneous FU0 push.
    step(0, 0, 4'hF, tags4(1, 2, 3, 4), {$urandom, $urandom, $urandom, $urandom}, 1, acc);
    step(0, 0, 4'b0001, tags4(9, 0, 0, 0), {96'h0, 32'h99}, 1, acc);
    step(0, 1, 4'b0001, tags4(30, 0, 0, 0), {96'h0, 32'hBAD}, 0, acc);
    for (int c = 0; c < 4; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    // Reset mid-stream while the bus is active: order restarts at FU0.
    step(0, 0, 4'b1100, tags4(0, 0, 3, 4), {$urandom, $urandom, $urandom, $urandom}, 1, acc);
    step(0, 0, 4'hF, tags4(5, 6, 7, 8), {$urandom, $urandom, $urandom, $urandom}, 1, acc);
    step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(1, 0, 4'b0, 20'b0, 128'b0, 0, acc);
    step(0, 0, 4'hF, tags4(0, 1, 2, 3), {$urandom, $urandom, $urandom, $urandom}, 1, acc);
    for (int c = 0; c < 6; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    // Randomized traffic with occasional squash and reset.
    for (int c = 0; c < 600; c++) begin
      r_in = ($urandom_range(99) < 1);
      s_in = ($urandom_range(99) < 3);
      v    = 4'($urandom);
      t    = 20'($urandom);
      d    = {$urandom, $urandom, $urandom, $urandom};
      step(r_in, s_in, v, t, d, $urandom_range(9) < 8, acc);
    end
    for (int c = 0; c < 6; c++) step(0, 0, 4'b0, 20'b0, 128'b0, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
